// File: rtl/hilo_mdu_controller.sv
// HI/LO multiply sequencer: iterative shift-add MULT/MULTU/MADD/MSUB plus MTHI/MTLO.
// Retires STEP multiplier bits per cycle; the sign is applied once, after the loop.
module hilo_mdu_controller #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        read_hilo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [63:0] hilo
);

    localparam int unsigned N     = 32 / STEP;
    localparam int unsigned CNT_W = $clog2(N) + 1;
    localparam int unsigned PP_W  = 32 + STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [31:0]        mcand_q, mcand_d;
    logic [31:0]        mplier_q, mplier_d;
    logic [63:0]        part_q, part_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        hilo_q, hilo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic               signed_op_c;
    logic [31:0]        a_mag_c, b_mag_c;
    logic [PP_W-1:0]    pp_c;
    logic [5:0]         sh_c;
    logic [63:0]        p_fix_c;

    assign accept_c = (state_q == IDLE) && start && !op[2];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = MUL;
            MUL:     if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        part_d   = part_q;
        cnt_d    = cnt_q;
        hilo_d   = hilo_q;
        busy_d   = (state_d != IDLE);
        done_d   = 1'b0;

        signed_op_c = (op[1:0] != 2'b01);
        a_mag_c     = (signed_op_c && a[31]) ? 32'(-a) : a;
        b_mag_c     = (signed_op_c && b[31]) ? 32'(-b) : b;
        pp_c        = PP_W'(mcand_q) * PP_W'(mplier_q[STEP-1:0]);
        sh_c        = 6'(32'(cnt_q) * STEP);
        p_fix_c     = neg_q ? 64'(-part_q) : part_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        op_d     = op[1:0];
                        mcand_d  = a_mag_c;
                        mplier_d = b_mag_c;
                        neg_d    = signed_op_c && (a[31] ^ b[31]);
                        part_d   = '0;
                        cnt_d    = '0;
                    end else if (op[1:0] == 2'b00) begin
                        hilo_d[63:32] = a;
                    end else if (op[1:0] == 2'b01) begin
                        hilo_d[31:0] = a;
                    end
                end
            end
            MUL: begin
                part_d   = part_q + (64'(pp_c) << sh_c);
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            FIX: begin
                done_d = 1'b1;
                case (op_q)
                    2'b10:   hilo_d = hilo_q + p_fix_c;
                    2'b11:   hilo_d = hilo_q - p_fix_c;
                    default: hilo_d = p_fix_c;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any multiply without committing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            part_q   <= '0;
            cnt_q    <= '0;
            hilo_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            part_q   <= part_d;
            cnt_q    <= cnt_d;
            hilo_q   <= hilo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hilo  = hilo_q;
    assign stall = busy_q && (read_hilo || start);

endmodule

// File: tb/tb_hilo_mdu_controller.sv
// Scoreboard bench for hilo_mdu_controller: directed and random ops against an arithmetic model.
module tb_hilo_mdu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        read_hilo;
    logic        busy, stall, done;
    logic [63:0] hilo;

    logic        start4;
    logic [2:0]  op4;
    logic [31:0] a4, b4;
    logic        read_hilo4;
    logic        busy4, stall4, done4;
    logic [63:0] hilo4;

    int          total = 0;
    int          bad = 0;
    int          busy_cnt = 0;
    logic [63:0] model = '0;
    logic [63:0] exp_q[$];

    hilo_mdu_controller #(.STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .read_hilo(read_hilo), .busy(busy), .stall(stall), .done(done), .hilo(hilo)
    );

    hilo_mdu_controller #(.STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
        .read_hilo(read_hilo4), .busy(busy4), .stall(stall4), .done(done4), .hilo(hilo4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: full 64-bit product with plain arithmetic, then accumulate
    function automatic logic [63:0] model_next(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] cur);
        longint     sx, sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 3'd1) p = {32'b0, x} * {32'b0, y};
        else           p = 64'(sx * sy);
        case (o)
            3'd2:    return cur + p;
            3'd3:    return cur - p;
            default: return p;
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
        int w = 0;
        @(negedge clk);
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            chk("issue_wait_timeout", 64'(busy), 64'(0));
            return;
        end
        start = 1'b1; op = o; a = x; b = y;
        if (!o[2]) begin
            if (push) begin
                model = model_next(o, x, y, model);
                exp_q.push_back(model);
            end
        end else if (o == 3'd4) begin
            model[63:32] = x;
        end else if (o == 3'd5) begin
            model[31:0] = x;
        end
        @(negedge clk);
        start = 1'b0;
        if (o[2]) chk("mt_or_ignored_op", hilo, model);
    endtask

    // Monitor: pops the scoreboard on each Done pulse
    task automatic monitor();
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy_cnt = 0;
                continue;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: hilo=%h with no pending multiply", hilo);
                end else begin
                    chk("mul_result", hilo, exp_q.pop_front());
                    chk("busy_cycles", 64'(busy_cnt), 64'(33));
                end
                busy_cnt = 0;
            end
        end
    endtask

    initial begin
        logic [63:0] held;
        int          cnt4;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; read_hilo = 1'b0;
        start4 = 1'b0; op4 = '0; a4 = '0; b4 = '0; read_hilo4 = 1'b0;
        fork
            monitor();
        join_none

        #2;
        chk("reset_hilo", hilo, 64'h0);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_stall", 64'(stall), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(3'd5, 32'd10, 32'd0, 1'b1);
        issue(3'd4, 32'd0, 32'd0, 1'b1);
        issue(3'd2, 32'd3, 32'd4, 1'b1);
        issue(3'd3, 32'd1, 32'd23, 1'b1);

        // Hazard: stall on read and on start while busy; MTHI while busy is dropped
        issue(3'd0, 32'h1234_5678, 32'hFFFF_FF00, 1'b1);
        repeat (4) @(negedge clk);
        read_hilo = 1'b1;
        #1 chk("stall_on_read", 64'(stall), 64'(1));
        read_hilo = 1'b0;
        #1 chk("no_stall_busy_quiet", 64'(stall), 64'(0));
        @(negedge clk);
        held = hilo;
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        #1 chk("stall_on_start", 64'(stall), 64'(1));
        @(negedge clk);
        start = 1'b0;
        chk("mthi_ignored_while_busy", hilo, held);
        while (busy) @(negedge clk);
        read_hilo = 1'b1;
        #1 chk("no_stall_idle", 64'(stall), 64'(0));
        read_hilo = 1'b0;

        // Abort by reset mid-multiply: no commit, no Done
        issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hilo", hilo, 64'h0);
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model = '0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done), 64'(0));

        for (int i = 0; i < 50; i++) begin
            issue(3'($urandom_range(0, 7)), rnd32(), rnd32(), 1'b1);
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        // STEP=4 instance: 8 iterations plus FIX
        @(negedge clk);
        start4 = 1'b1; op4 = 3'd1; a4 = 32'h1234_5678; b4 = 32'h9ABC_DEF0;
        @(negedge clk);
        start4 = 1'b0;
        cnt4 = 0;
        for (int i = 0; i < 40 && !done4; i++) begin
            if (busy4) cnt4++;
            @(negedge clk);
        end
        chk("step4_done_seen", 64'(done4), 64'(1));
        chk("step4_busy_cycles", 64'(cnt4), 64'(9));
        chk("step4_result", hilo4, model_next(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0));
        @(negedge clk);
        chk("step4_done_one_cycle", 64'(done4), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_controller.md
# hilo_mdu_controller

Sequencer for the HI/LO multiply path. It owns the 64-bit HI/LO register and runs MULT, MULTU, MADD and MSUB as a multi-cycle iterative shift-add multiply, so the single-cycle ALU no longer needs a combinational 32×32 multiplier. It sits beside the ALU in the execute stage. It takes operands from the register-read stage and presents {HI,LO} to the MFHI/MFLO path. It raises a stall to the hazard unit while a multiply is in flight.

## Interface
- STEP, 1: multiplier bits retired per cycle; legal values 1, 2, 4, 8. N = 32/STEP iteration cycles.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe, sampled each rising edge.
- Op  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored: no state change.
- A  in  32  operand rs; the value for MTHI/MTLO.
- B  in  32  operand rt.
- ReadHiLo  in  1  an MFHI/MFLO is in execute this cycle.
- Busy  out  1  registered; a multiply is in flight.
- Stall  out  1  combinational; freeze the pipeline.
- Done  out  1  registered one-cycle pulse; a multiply result was committed.
- HiLo  out  64  registered {HI[63:32], LO[31:0]}.

## Operation
- States: IDLE, MUL, FIX.
- IDLE, Start=1, Op in {000..011}:
  - Latch Op.
  - Latch the multiplicand magnitude |A| and multiplier magnitude |B| as 32-bit unsigned. For MULTU these are A and B unchanged.
  - Latch neg = A[31]^B[31] for signed ops; neg = 0 for MULTU.
  - Clear the 64-bit partial product and the iteration counter; go to MUL.
- Magnitude rule: 0x80000000 has magnitude 0x80000000, which is representable unsigned. No special case.
- MUL:
  - Each cycle, examine the low STEP bits of the multiplier.
  - Add (multiplicand × those bits) << (count×STEP) into the 64-bit partial product.
  - Shift the multiplier right by STEP; increment the counter.
  - After N cycles go to FIX.
- FIX:
  - P = neg ? −partial : partial, in two's complement mod 2^64.
  - Commit to HiLo:
    - MULT/MULTU: HiLo ← P.
    - MADD: HiLo ← HiLo + P.
    - MSUB: HiLo ← HiLo − P.
  - All arithmetic is mod 2^64; overflow is discarded silently.
  - Go to IDLE.
- IDLE, Start=1, Op=100: HI ← A at that edge; LO unchanged; stay IDLE; no Busy, no Done.
- IDLE, Start=1, Op=101: LO ← A at that edge; HI unchanged; stay IDLE; no Busy, no Done.
- Start while Busy=1: not accepted and not queued. Stall holds the requester, which re-presents the request.
- Stall = Busy & (ReadHiLo | Start).
- HiLo never changes during MUL. It changes only at the FIX edge or an IDLE MTHI/MTLO edge.

## Timing
- Reset (Rst_n=0, asynchronous):
  - State = IDLE; HiLo = 0; Busy = 0; Done = 0.
  - Counter, partial product and latched operands = 0.
  - A multiply in progress is aborted with no commit.
- Accepting edge e0: Busy = 1 after e0.
- MUL occupies edges e1..eN; FIX commits at edge eN+1.
- After eN+1: HiLo = new value, Done = 1 for exactly one cycle, Busy = 0.
- Busy is high for N+1 cycles (33 for STEP=1).
- A new Start is accepted in the cycle where Done=1 (Busy=0). Back-to-back multiplies have no bubble.
- MTHI/MTLO latency: 1 edge. A Start in the cycle after an MTHI sees the updated HI; MADD/MSUB therefore accumulate onto it.
- The MADD/MSUB accumulate operand is HiLo at the FIX edge. It equals HiLo at acceptance, because nothing else writes while busy.
- Stall is combinational from ReadHiLo/Start and registered Busy. In the Done cycle Stall = 0, so an MFHI in that cycle reads the new HiLo.
- Rst_n deassertion has no edge of its own. The first Start is sampled at the first rising edge with Rst_n=1.

## Test plan
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF, STEP=1:
  - Busy for 33 cycles.
  - Done after edge 33; HiLo=0xFFFFFFFE_00000001.
- MULT, A=0xFFFFFFFE (−2), B=3 → HiLo=0xFFFFFFFF_FFFFFFFA.
- MULT, A=0x80000000, B=0x80000000 → HiLo=0x40000000_00000000.
- MTLO A=10, then MTHI A=0, then MADD A=3, B=4 → HiLo=0x00000000_00000016.
- Follow-up MSUB A=1, B=23 → HiLo=0xFFFFFFFF_FFFFFFFF.
- Hazard and abort, during a MULT:
  - ReadHiLo=1 at cycle 5 → Stall=1.
  - Start with MTHI at cycle 6 → ignored; HI unchanged at completion.
  - Rst_n pulsed low at cycle 10 → HiLo=0, Busy=0 immediately; no Done pulse.
- STEP=4, MULTU A=0x12345678, B=0x9ABCDEF0:
  - Busy for 9 cycles.
  - HiLo=0x0B00EA4E_242D2080.
